alarm_zone_ctrl: RTL and testbench
==================================

# alarm_zone_ctrl

Parametrised anti-theft controller for N door/hatch zones: main alarm FSM, passive-arming sub-FSM and a shared seconds down-counter in one block. Sits between the input debouncers and the siren/display drivers; consumes a 1 Hz enable tick from the clock-enable generator. Adds per-zone entry delays, runtime-loadable durations, re-arm after alarm timeout, and optional first-trip zone capture.

## Interface
- N_ZONES, 4, number of door zones; bit 0 is the driver door; must be ≥2
- CNT_W, 4, width of the seconds counter and all duration inputs
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clock
- tick_1hz  in  1  one-cycle enable, once per second
- ignition  in  1  debounced ignition switch, 1 = on
- zone  in  N_ZONES  debounced door contacts, 1 = open
- t_arm, t_driver, t_pass, t_alarm  in  CNT_W each  durations in seconds, sampled only on counter load
- armed  out  1  1 when state = ARMED
- siren_en  out  1  1 when state = ALARM
- state  out  3  encoded main state, for display
- count  out  CNT_W  remaining seconds of the active countdown
- trip_zone  out  N_ZONES  zone vector captured at trip; 0 when ALARM_TRIP_LOG_EN is undefined

## Operation
- Main FSM encodings: ARMED=0, DISARMED=1, TRIGGERED=2, ALARM=3, ALARM_HOLD=4; any other value → ARMED next cycle.
- Ignition on forces DISARMED from every state; highest priority.
- ARMED: any zone open → TRIGGERED; load t_driver if zone[0] open, else t_pass (driver wins on simultaneous openings).
- TRIGGERED: expired → ALARM. Closing doors does not cancel.
- ALARM: all zones closed → ALARM_HOLD, load t_alarm.
- ALARM_HOLD: any zone open → ALARM (counter stopped); expired → ARMED.
- DISARMED: arming FSM in ARM_DELAY and expired → ARMED.
- Arming FSM (advances only while main = DISARMED, else forced to WAIT_IGN_OFF): WAIT_IGN_OFF: ignition off → WAIT_DOOR_OPEN. WAIT_DOOR_OPEN: zone[0] open → WAIT_DOOR_CLOSE. WAIT_DOOR_CLOSE: all zones closed → ARM_DELAY, load t_arm. ARM_DELAY: any zone open → WAIT_DOOR_CLOSE, counter stopped. Ignition on in any of these → WAIT_IGN_OFF.
- Counter: load sets count = value, running = 1. With running and tick_1hz and count > 0: count − 1. expired = running && count == 0 (level). Leaving the state that started the countdown clears running. Load of 0 expires one cycle after load.
- trip_zone: on ARMED → TRIGGERED, captures zone; held until the next trip or reset.

## Timing
- Reset values: main = ARMED, arming FSM = WAIT_IGN_OFF, count = 0, running = 0, trip_zone = 0; so armed = 1, siren_en = 0, state = 0.
- All state, count, running, trip_zone registered; outputs are decodes of registered state, valid the cycle after the causing input.
- Load and tick in the same cycle: load wins, no decrement.
- Entry delay of D seconds: ALARM entered on the cycle after the D-th tick following the load.
- Inputs are pre-synchronised; no internal debounce.
- Reset mid-countdown: counter cleared, system returns to ARMED immediately.

## Configuration
- ALARM_TRIP_LOG_EN defined: trip_zone register implemented as above.
- Undefined: no register; trip_zone tied to 0; all other behaviour identical.

## Test plan
- Reset, zone=0001, t_driver=3 → TRIGGERED, count 3,2,1,0 on ticks, siren_en=1 one cycle after 3rd tick; trip_zone=0001 with macro.
- ARMED, zone=0100, t_pass=5; ignition=1 after 2 ticks → DISARMED next cycle, siren_en never asserted.
- ALARM, close all zones, t_alarm=4 → ALARM_HOLD; reopen zone[2] after 2 ticks → ALARM; close, wait 4 ticks → ARMED.
- DISARMED, ignition off, zone[0] open then close, t_arm=2 → armed=1 after 2 ticks; reopening zone[1] during delay returns arming to WAIT_DOOR_CLOSE, armed stays 0.
- zone=1010 simultaneous in ARMED, t_driver=2, t_pass=9 → count loads 9 (zone[0] closed); zone=0011 → count loads t_driver.
- Load with tick_1hz in same cycle, t_driver=1 → count=1 after load, 0 after next tick; reset asserted mid-ALARM → armed=1, count=0.

Source files
------------

// File: rtl/alarm_zone_ctrl.sv
// alarm_zone_ctrl: anti-theft controller with main alarm FSM, passive-arming FSM and shared seconds counter.
// Define ALARM_TRIP_LOG_EN to capture the zone vector that caused each trip on trip_zone_o.
module alarm_zone_ctrl #(
    parameter int N_ZONES = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_1hz_i,
    input  logic               ignition_i,
    input  logic [N_ZONES-1:0] zone_i,
    input  logic [CNT_W-1:0]   t_arm_i,
    input  logic [CNT_W-1:0]   t_driver_i,
    input  logic [CNT_W-1:0]   t_pass_i,
    input  logic [CNT_W-1:0]   t_alarm_i,
    output logic               armed_o,
    output logic               siren_en_o,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   count_o,
    output logic [N_ZONES-1:0] trip_zone_o
);
    localparam logic [2:0] ARMED      = 3'd0;
    localparam logic [2:0] DISARMED   = 3'd1;
    localparam logic [2:0] TRIGGERED  = 3'd2;
    localparam logic [2:0] ALARM      = 3'd3;
    localparam logic [2:0] ALARM_HOLD = 3'd4;
    localparam logic [1:0] WAIT_IGN_OFF    = 2'd0;
    localparam logic [1:0] WAIT_DOOR_OPEN  = 2'd1;
    localparam logic [1:0] WAIT_DOOR_CLOSE = 2'd2;
    localparam logic [1:0] ARM_DELAY       = 2'd3;
    logic [2:0]       main_q, main_d;
    logic [1:0]       arm_q, arm_d;
    logic [CNT_W-1:0] count_q, count_d, main_val, load_val;
    logic             run_q, run_d;
    logic             main_load, arm_load, load, stop, expired, any_open;
    assign any_open = |zone_i;
    assign expired  = run_q && (count_q == '0);
    always_comb begin
        main_d    = main_q;
        main_load = 1'b0;
        main_val  = '0;
        if (ignition_i) begin
            main_d = DISARMED;
        end else begin
            case (main_q)
                ARMED: if (any_open) begin
                    main_d    = TRIGGERED;
                    main_load = 1'b1;
                    main_val  = zone_i[0] ? t_driver_i : t_pass_i;
                end
                TRIGGERED: if (expired) main_d = ALARM;
                ALARM: if (!any_open) begin
                    main_d    = ALARM_HOLD;
                    main_load = 1'b1;
                    main_val  = t_alarm_i;
                end
                ALARM_HOLD: main_d = any_open ? ALARM : (expired ? ARMED : ALARM_HOLD);
                DISARMED: if (arm_q == ARM_DELAY && expired) main_d = ARMED;
                default: main_d = ARMED;
            endcase
        end
    end
    // The arming FSM only runs while disarmed; anywhere else it waits for the next ignition-off.
    always_comb begin
        arm_d    = arm_q;
        arm_load = 1'b0;
        if (main_q != DISARMED || ignition_i) begin
            arm_d = WAIT_IGN_OFF;
        end else begin
            case (arm_q)
                WAIT_IGN_OFF:   arm_d = WAIT_DOOR_OPEN;
                WAIT_DOOR_OPEN: if (zone_i[0]) arm_d = WAIT_DOOR_CLOSE;
                WAIT_DOOR_CLOSE: if (!any_open) begin
                    arm_d    = ARM_DELAY;
                    arm_load = 1'b1;
                end
                default: if (any_open) arm_d = WAIT_DOOR_CLOSE;
            endcase
        end
    end
    // Leaving the state that owns the countdown freezes it; a stopped count keeps its value.
    assign load     = main_load | arm_load;
    assign load_val = arm_load ? t_arm_i : main_val;
    assign stop     = (main_d != main_q) || (arm_q == ARM_DELAY && arm_d != ARM_DELAY);
    assign run_d    = load | (run_q & ~stop);
    assign count_d  = load ? load_val
                    : (run_q && !stop && tick_1hz_i && count_q != '0) ? count_q - 1'b1
                    : count_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q  <= ARMED;
            arm_q   <= WAIT_IGN_OFF;
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            main_q  <= main_d;
            arm_q   <= arm_d;
            count_q <= count_d;
            run_q   <= run_d;
        end
    end
`ifdef ALARM_TRIP_LOG_EN
    logic [N_ZONES-1:0] trip_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) trip_q <= '0;
        else if (main_q == ARMED && main_d == TRIGGERED) trip_q <= zone_i;
    end
    assign trip_zone_o = trip_q;
`else
    assign trip_zone_o = '0;
`endif
    assign armed_o    = (main_q == ARMED);
    assign siren_en_o = (main_q == ALARM);
    assign state_o    = main_q;
    assign count_o    = count_q;
endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// tb_alarm_zone_ctrl: directed vector table plus hand sequences for alarm_zone_ctrl.
module tb_alarm_zone_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz_i = 1'b0;
    logic       ignition_i = 1'b0;
    logic [3:0] zone_i = '0;
    logic [3:0] t_arm_i = 4'd2, t_driver_i = 4'd3, t_pass_i = 4'd5, t_alarm_i = 4'd4;
    logic       armed_o, siren_en_o;
    logic [2:0] state_o;
    logic [3:0] count_o, trip_zone_o;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       tick;
        logic       ign;
        logic [3:0] zone;
        logic [2:0] st;
        logic [3:0] cnt;
    } vec_t;
    vec_t vq[$];

    alarm_zone_ctrl #(.N_ZONES(4), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .tick_1hz_i(tick_1hz_i), .ignition_i(ignition_i),
        .zone_i(zone_i), .t_arm_i(t_arm_i), .t_driver_i(t_driver_i), .t_pass_i(t_pass_i),
        .t_alarm_i(t_alarm_i), .armed_o(armed_o), .siren_en_o(siren_en_o), .state_o(state_o),
        .count_o(count_o), .trip_zone_o(trip_zone_o)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic tk, input logic ig, input logic [3:0] z,
                                input logic [2:0] s, input logic [3:0] c);
        vec_t v;
        v.tick = tk; v.ign = ig; v.zone = z; v.st = s; v.cnt = c;
        return v;
    endfunction

    function automatic logic [3:0] trip_exp(input logic [3:0] z);
`ifdef ALARM_TRIP_LOG_EN
        return z;
`else
        return 4'd0 & z;
`endif
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s #%0d: got %0d expected %0d", nm, idx, got, exp);
        end
    endtask

    task automatic step(input logic tk, input logic ig, input logic [3:0] z);
        tick_1hz_i = tk;
        ignition_i = ig;
        zone_i     = z;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string nm, input int idx, input logic [2:0] s, input logic [3:0] c);
        chk({nm, "_state"}, idx, 32'(state_o), 32'(s));
        chk({nm, "_count"}, idx, 32'(count_o), 32'(c));
        chk({nm, "_armed"}, idx, 32'(armed_o), 32'(s == 3'd0));
        chk({nm, "_siren"}, idx, 32'(siren_en_o), 32'(s == 3'd3));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_1hz_i = 1'b0;
        ignition_i = 1'b0;
        zone_i = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        // driver door trip, entry delay 3, then alarm / hold / re-open / re-arm
        vq.push_back(mk(0, 0, 4'b0001, 3'd2, 4'd3));
        vq.push_back(mk(1, 0, 4'b0100, 3'd2, 4'd2));
        vq.push_back(mk(0, 0, 4'b0100, 3'd2, 4'd2));
        vq.push_back(mk(1, 0, 4'b0100, 3'd2, 4'd1));
        vq.push_back(mk(1, 0, 4'b0100, 3'd2, 4'd0));
        vq.push_back(mk(0, 0, 4'b0100, 3'd3, 4'd0));
        vq.push_back(mk(1, 0, 4'b0100, 3'd3, 4'd0));
        vq.push_back(mk(0, 0, 4'b0000, 3'd4, 4'd4));
        vq.push_back(mk(1, 0, 4'b0000, 3'd4, 4'd3));
        vq.push_back(mk(1, 0, 4'b0000, 3'd4, 4'd2));
        vq.push_back(mk(0, 0, 4'b0100, 3'd3, 4'd2));
        vq.push_back(mk(1, 0, 4'b0100, 3'd3, 4'd2));
        vq.push_back(mk(0, 0, 4'b0000, 3'd4, 4'd4));
        vq.push_back(mk(1, 0, 4'b0000, 3'd4, 4'd3));
        vq.push_back(mk(1, 0, 4'b0000, 3'd4, 4'd2));
        vq.push_back(mk(1, 0, 4'b0000, 3'd4, 4'd1));
        vq.push_back(mk(1, 0, 4'b0000, 3'd4, 4'd0));
        vq.push_back(mk(0, 0, 4'b0000, 3'd0, 4'd0));
        // passenger trip, ignition cancels after two ticks
        vq.push_back(mk(0, 0, 4'b0100, 3'd2, 4'd5));
        vq.push_back(mk(1, 0, 4'b0100, 3'd2, 4'd4));
        vq.push_back(mk(1, 0, 4'b0100, 3'd2, 4'd3));
        vq.push_back(mk(0, 1, 4'b0100, 3'd1, 4'd3));
        vq.push_back(mk(1, 1, 4'b0000, 3'd1, 4'd3));
        // passive arming with an interrupted delay
        vq.push_back(mk(0, 0, 4'b0000, 3'd1, 4'd3));
        vq.push_back(mk(0, 0, 4'b0001, 3'd1, 4'd3));
        vq.push_back(mk(0, 0, 4'b0000, 3'd1, 4'd2));
        vq.push_back(mk(1, 0, 4'b0000, 3'd1, 4'd1));
        vq.push_back(mk(0, 0, 4'b0010, 3'd1, 4'd1));
        vq.push_back(mk(1, 0, 4'b0010, 3'd1, 4'd1));
        vq.push_back(mk(0, 0, 4'b0000, 3'd1, 4'd2));
        vq.push_back(mk(1, 0, 4'b0000, 3'd1, 4'd1));
        vq.push_back(mk(1, 0, 4'b0000, 3'd1, 4'd0));
        vq.push_back(mk(0, 0, 4'b0000, 3'd0, 4'd0));

        do_reset();
        chk_state("reset", 0, 3'd0, 4'd0);
        chk("reset_trip", 0, 32'(trip_zone_o), 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].tick, vq[i].ign, vq[i].zone);
            chk_state("vec", i, vq[i].st, vq[i].cnt);
        end
        chk("trip_held", 0, 32'(trip_zone_o), 32'(trip_exp(4'b0100)));

        // simultaneous openings: passenger-only load, then driver wins
        t_driver_i = 4'd2;
        t_pass_i   = 4'd9;
        step(0, 0, 4'b1010);
        chk_state("simul_pass", 0, 3'd2, 4'd9);
        chk("simul_pass_trip", 0, 32'(trip_zone_o), 32'(trip_exp(4'b1010)));
        do_reset();
        step(0, 0, 4'b0011);
        chk_state("simul_drv", 0, 3'd2, 4'd2);
        chk("simul_drv_trip", 0, 32'(trip_zone_o), 32'(trip_exp(4'b0011)));

        // zero-length delay expires one cycle after load
        do_reset();
        t_pass_i = 4'd0;
        step(0, 0, 4'b0100);
        chk_state("zero_load", 0, 3'd2, 4'd0);
        step(0, 0, 4'b0100);
        chk_state("zero_exp", 0, 3'd3, 4'd0);

        // load and tick together: load wins; then async reset mid-alarm
        do_reset();
        t_driver_i = 4'd1;
        step(1, 0, 4'b0001);
        chk_state("ldtick", 0, 3'd2, 4'd1);
        step(1, 0, 4'b0001);
        chk_state("ldtick", 1, 3'd2, 4'd0);
        step(0, 0, 4'b0001);
        chk_state("ldtick", 2, 3'd3, 4'd0);
        reset = 1'b1;
        #2;
        chk_state("async_rst", 0, 3'd0, 4'd0);
        chk("async_rst_trip", 0, 32'(trip_zone_o), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        step(0, 0, 4'b0000);
        chk_state("post_rst", 0, 3'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
